// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: sends a WIDTH-bit word LSB first, one bit per en strobe.
// Optional macro SER_PARITY_EN appends an even-parity bit after the data bits.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] p_in,
    output logic             d_out,
    output logic             tx_valid,
    output logic             busy,
    output logic             done
);

`ifdef SER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CNT_W = $clog2(NBITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [NBITS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [NBITS-1:0]   load_word;

`ifdef SER_PARITY_EN
    // Parity rides in the top bit so it falls out of the shifter after the data.
    assign load_word = {^p_in, p_in};
`else
    assign load_word = p_in;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Handshake: a word transfers at an edge where load_valid && load_ready;
    // load_ready is high only in IDLE, so offers made while shifting are ignored.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        load_ready = 1'b0;
        busy       = 1'b0;
        tx_valid   = 1'b0;
        d_out      = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    shreg_d = load_word;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                d_out    = shreg_q[0];
                tx_valid = en;
                if (en) begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: models the 4-bit receiver and checks every serial bit and done pulse.
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] p_in;
    logic       d_out;
    logic       tx_valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [0:0] exp_q[$];
    logic [3:0] rx = 4'b0000;
    logic       exp_done = 1'b0;
    logic       mon_on = 1'b0;

    piso_serializer #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .p_in      (p_in),
        .d_out     (d_out),
        .tx_valid  (tx_valid),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] rx_exp(input logic [3:0] w);
`ifdef SER_PARITY_EN
        return {^w, w[3:1]};
`else
        return w;
`endif
    endfunction

    // Receiver model plus bit scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic nxt;
        logic [0:0] b;
        nxt = 1'b0;
        if (mon_on) begin
            check("done", done, exp_done);
            if (rst && load_ready) check("idle_out", {d_out, tx_valid}, 2'b00);
            if (rst && tx_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_bit", tx_valid, 1'b0);
                end else begin
                    b = exp_q.pop_front();
                    check("d_out", d_out, b);
                    rx = {d_out, rx[3:1]};
                    nxt = (exp_q.size() == 0);
                end
            end else if (rst && busy && exp_q.size() != 0) begin
                check("d_out_hold", d_out, exp_q[0]);
            end
        end
        exp_done = nxt;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [3:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
`ifdef SER_PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    task automatic do_load(input logic [3:0] w, input logic en_v);
        check("load_ready", load_ready, 1'b1);
        load_valid = 1'b1;
        p_in       = w;
        en         = en_v;
        push_word(w);
        tick();
        load_valid = 1'b0;
        p_in       = 4'($urandom_range(0, 15));
    endtask

    task automatic strobes(input int n);
        en = 1'b1;
        repeat (n) tick();
    endtask

    localparam int NB =
`ifdef SER_PARITY_EN
        5;
`else
        4;
`endif

    initial begin
        logic [6:0] pat;
        rst = 1'b0; en = 1'b0; load_valid = 1'b0; p_in = 4'h0;

        // Reset then idle
        tick(); tick();
        check("rst_ready", load_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_out", {d_out, tx_valid, done}, 3'b000);
        rst = 1'b1;
        mon_on = 1'b1;
        tick();

        // Basic word, en high through the accept cycle too
        do_load(4'b1011, 1'b1);
        check("basic_busy", {busy, load_ready}, 2'b10);
        strobes(NB);
        check("basic_done", done, 1'b1);
        check("basic_ready", load_ready, 1'b1);
        en = 1'b0;
        tick();
        check("basic_done_clr", done, 1'b0);
        check("basic_rx", rx, rx_exp(4'b1011));

        // Gapped enable: 1,0,0,1,1,0,1
        do_load(4'b0110, 1'b0);
        pat = 7'b1011001;
        for (int i = 0; i < 7; i++) begin
            en = pat[i];
            tick();
            if (i < 6) check("gap_no_done", done, 1'b0);
        end
`ifdef SER_PARITY_EN
        strobes(1);
`endif
        check("gap_done", done, 1'b1);
        en = 1'b0;
        tick();
        check("gap_rx", rx, rx_exp(4'b0110));

        // Busy collision: offer 1111 during the shift of 1001
        do_load(4'b1001, 1'b1);
        load_valid = 1'b1;
        p_in = 4'b1111;
        for (int i = 0; i < NB; i++) begin
            check("coll_not_ready", load_ready, 1'b0);
            tick();
        end
        check("coll_rx", rx, rx_exp(4'b1001));
        check("coll_ready", load_ready, 1'b1);
        push_word(4'b1111);
        tick();
        load_valid = 1'b0;
        check("coll_busy", busy, 1'b1);
        strobes(NB);
        en = 1'b0;
        tick();
        check("coll_rx2", rx, rx_exp(4'b1111));

        // Reset mid-word after two bits
        do_load(4'b1100, 1'b1);
        strobes(2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_txv", tx_valid, 1'b0);
        check("mid_rst_ready", load_ready, 1'b1);
        check("mid_rst_done", done, 1'b0);
        en = 1'b0;
        tick();
        do_load(4'b0101, 1'b1);
        strobes(NB);
        check("post_rst_done", done, 1'b1);
        en = 1'b0;
        tick();
        check("post_rst_rx", rx, rx_exp(4'b0101));

        // Word whose parity is 0
        do_load(4'b0011, 1'b1);
        strobes(NB);
        en = 1'b0;
        tick();
        check("par0_rx", rx, rx_exp(4'b0011));

        tick();
        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter for the bit-serial link whose receiving end is the team's 4-bit serial-in shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enable strobe, LSB first.
- Drives `tx_valid` as the receiver's shift enable, so the receiver ends with word bit 0 in its A stage and bit WIDTH-1 in its D stage.
- Sits between the parallel datapath and the serial link.

Parameters:
- WIDTH, 4, data word width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- en  input  1  bit-pacing strobe; one serial bit advances per cycle with en=1 while shifting.
- load_valid  input  1  parallel word offered.
- load_ready  output  1  block can accept a word this cycle.
- p_in  input  WIDTH  parallel word; p_in[0] is transmitted first.
- d_out  output  1  serial data bit; connects to the receiver's d_in.
- tx_valid  output  1  qualifies d_out; connects to the receiver's en.
- busy  output  1  high while a word is being shifted.
- done  output  1  one-cycle pulse after the last bit of a word is sent.

Behaviour:
- State machine states:
  - IDLE: load_ready=1, busy=0, tx_valid=0, d_out=0.
  - SHIFT: load_ready=0, busy=1, d_out=shreg[0], tx_valid=en.
- Registers: shreg[WIDTH-1:0], bit counter cnt (clog2(WIDTH+1) bits), state, done.
- Reset (rst=0 at a clock edge): state=IDLE, shreg=0, cnt=0, done=0. This gives d_out=0, tx_valid=0, busy=0 and load_ready=1 from the first cycle after reset. Reset overrides every other input and aborts any word in flight; the partial word is discarded and not resumed.
- Accept: in IDLE with load_valid=1 at an edge, shreg<=p_in, cnt<=0, state<=SHIFT. Latency from the accept edge to the first valid bit on d_out is 1 cycle.
- Shift: in SHIFT with en=1 at an edge:
  - shreg<=shreg>>1 (MSB fills with 0), cnt<=cnt+1.
  - If cnt==WIDTH-1: state<=IDLE, done<=1.
- en=0 in SHIFT: everything holds, d_out stays stable, tx_valid=0. Gaps of any length are legal.
- done is high for exactly the one cycle following the edge that transmits the final bit, and is 0 otherwise.
- A word needs exactly WIDTH cycles with en=1. The minimum word period is WIDTH+1 cycles, because load_ready is low throughout SHIFT and there is one IDLE cycle between words.
- load_valid while in SHIFT: ignored. No capture occurs and the word in flight is not disturbed; the upstream must hold the word until load_ready=1.
- en in IDLE: ignored, and tx_valid stays 0.
- load_valid=1 and en=1 in the same IDLE cycle: the word is accepted, and en has no shift effect in that cycle.
- p_in may change freely after the accept edge.

Optional Feature:
- Macro: SER_PARITY_EN.
- When defined:
  - After the WIDTH data bits, one extra even-parity bit (XOR of the accepted word, captured at accept) is sent with tx_valid=en.
  - A word takes WIDTH+1 en strobes, and done pulses after the parity bit.
  - cnt terminal value becomes WIDTH.
- When undefined: no parity logic; exactly WIDTH bits per word.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then 1 -> load_ready=1, busy=0, d_out=0, tx_valid=0, done=0.
- Basic word: p_in=4'b1011 with load_valid for 1 cycle, en=1 constant -> tx_valid high for 4 cycles; d_out=1,1,0,1; done pulses once in the next cycle; load_ready returns to 1. The attached 4-bit receiver then shows A=1, B=1, C=0, D=1.
- Gapped enable: p_in=4'b0110, en pattern 1,0,0,1,1,0,1 -> d_out bits 0,1,1,0 are presented only on en=1 cycles, d_out is held during gaps, done occurs after the 4th strobe.
- Busy collision: load 4'b1001, then assert load_valid with p_in=4'b1111 during SHIFT -> 4'b1111 is not captured, the serial output is 1,0,0,1, and 4'b1111 is accepted only in the following IDLE cycle.
- Reset mid-word: load 4'b1100, drop rst for 1 cycle after 2 bits -> next cycle state=IDLE, tx_valid=0, no done pulse, and the next load transmits normally.
- Parity (SER_PARITY_EN defined): p_in=4'b1011 -> 5 strobes; d_out=1,1,0,1,1 (parity=1); done after the 5th. p_in=4'b0011 -> parity bit 0.
